mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / loader) arbiter for a single-port 512x32 synchronous RAM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the CPU always wins ties.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [8:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [8:0]  ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] ld_rdata,
  output logic        ld_ack,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  gnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        any_req;
  logic        pick_ld;
  logic        grant_now;
  logic        lat_we;
  logic [8:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  owner;

  assign any_req   = cpu_req | ld_req;
  assign grant_now = (state == IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_ld = 1 means the loader owned the most recent grant; it loses the next tie.
  logic last_ld;

  always_comb begin
    pick_ld = ld_req && (!cpu_req || !last_ld);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_ld <= 1'b1;
    end else if (grant_now) begin
      last_ld <= pick_ld;
    end
  end
`else
  always_comb begin
    pick_ld = ld_req && !cpu_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = CAPTURE;
      CAPTURE: next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = (state == ACCESS) && !lat_we;
    mem_write = (state == ACCESS) && lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    busy      = (state != IDLE);
    gnt       = owner;
  end

  // Only the owner's ack/rdata move; rdata loads on reads only, when RAM data is valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      owner     <= 2'b00;
      cpu_ack   <= 1'b0;
      ld_ack    <= 1'b0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else begin
      if (grant_now) begin
        lat_we    <= pick_ld ? ld_we    : cpu_we;
        lat_addr  <= pick_ld ? ld_addr  : cpu_addr;
        lat_wdata <= pick_ld ? ld_wdata : cpu_wdata;
        owner     <= pick_ld ? 2'b10    : 2'b01;
      end
      if (state == CAPTURE) begin
        if (owner[0]) begin
          cpu_ack <= 1'b1;
          if (!lat_we) cpu_rdata <= mem_rdata;
        end
        if (owner[1]) begin
          ld_ack <= 1'b1;
          if (!lat_we) ld_rdata <= mem_rdata;
        end
      end
      if (state == DONE) begin
        cpu_ack <= 1'b0;
        ld_ack  <= 1'b0;
        owner   <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 512x32 synchronous RAM.
// Expected tie winners follow MEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [8:0]  cpu_addr, ld_addr, mem_addr;
  logic [31:0] cpu_wdata, ld_wdata, cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, ld_ack, mem_read, mem_write, busy;
  logic [1:0]  gnt;
  logic [31:0] ram [0:511];
  int          checks;
  int          passed;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata),
    .gnt(gnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared RAM: read data appears one cycle after mem_read.
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic creq, input logic cwe, input logic [8:0] caddr,
                               input logic [31:0] cwdata, input logic lreq, input logic lwe,
                               input logic [8:0] laddr, input logic [31:0] lwdata);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwdata;
    ld_req = lreq; ld_we = lwe; ld_addr = laddr; ld_wdata = lwdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    mem_rdata = '0;
    reset = 1'b0;
    applyStimulus(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    tick(); tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_cpu_ack", cpu_ack, 0);
    checkOutput("rst_ld_ack", ld_ack, 0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 0);
    checkOutput("rst_ld_rdata", ld_rdata, 0);
    checkOutput("rst_mem_rw", {mem_read, mem_write}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;
    tick();

    $display("[TB] CPU write 0x055");
    applyStimulus(1, 1, 9'h055, 32'h0000_0085, 0, 0, 9'h0, 32'h0);
    tick();
    checkOutput("wr_mem_write", mem_write, 1);
    checkOutput("wr_mem_read", mem_read, 0);
    checkOutput("wr_mem_addr", mem_addr, 9'h055);
    checkOutput("wr_mem_wdata", mem_wdata, 32'h85);
    checkOutput("wr_gnt", gnt, 2'b01);
    checkOutput("wr_busy", busy, 1);
    applyStimulus(0, 0, 9'h1FF, 32'hFFFF_FFFF, 0, 0, 9'h0, 32'h0);
    tick();
    checkOutput("wr_capture_rw", {mem_read, mem_write}, 0);
    checkOutput("wr_addr_hold", mem_addr, 9'h055);
    checkOutput("wr_capture_ack", cpu_ack, 0);
    tick();
    checkOutput("wr_ack", cpu_ack, 1);
    checkOutput("wr_cpu_rdata", cpu_rdata, 0);
    checkOutput("wr_ld_ack", ld_ack, 0);
    tick();
    checkOutput("wr_idle_ack", cpu_ack, 0);
    checkOutput("wr_idle_busy", busy, 0);
    checkOutput("wr_idle_gnt", gnt, 0);

    $display("[TB] CPU read 0x055");
    applyStimulus(1, 0, 9'h055, 32'h0, 0, 0, 9'h0, 32'h0);
    tick();
    checkOutput("rd_mem_read", mem_read, 1);
    checkOutput("rd_mem_write", mem_write, 0);
    applyStimulus(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    tick(); tick();
    checkOutput("rd_ack", cpu_ack, 1);
    checkOutput("rd_cpu_rdata", cpu_rdata, 32'h85);
    checkOutput("rd_ld_ack", ld_ack, 0);
    checkOutput("rd_ld_rdata", ld_rdata, 0);
    tick();

    $display("[TB] loader request during CPU access");
    applyStimulus(1, 1, 9'h100, 32'hCAFE_0123, 0, 0, 9'h0, 32'h0);
    tick();
    checkOutput("lw_gnt_cpu", gnt, 2'b01);
    applyStimulus(0, 0, 9'h0, 32'h0, 1, 0, 9'h100, 32'h0);
    tick(); tick();
    checkOutput("lw_cpu_ack", cpu_ack, 1);
    checkOutput("lw_cpu_rdata_kept", cpu_rdata, 32'h85);
    checkOutput("lw_gnt_still_cpu", gnt, 2'b01);
    tick();
    checkOutput("lw_idle_busy", busy, 0);
    tick();
    checkOutput("lw_gnt_ld", gnt, 2'b10);
    checkOutput("lw_ld_mem_read", mem_read, 1);
    checkOutput("lw_ld_mem_addr", mem_addr, 9'h100);
    applyStimulus(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    tick(); tick();
    checkOutput("lw_ld_ack", ld_ack, 1);
    checkOutput("lw_ld_rdata", ld_rdata, 32'hCAFE_0123);
    checkOutput("lw_cpu_ack_quiet", cpu_ack, 0);
    checkOutput("lw_cpu_rdata_quiet", cpu_rdata, 32'h85);
    tick();

    $display("[TB] simultaneous requests held for four transactions");
    applyStimulus(1, 1, 9'h020, 32'h0000_000A, 1, 1, 9'h021, 32'h0000_000B);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_gnt;
      exp_gnt = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
      tick();
      checkOutput($sformatf("tie%0d_gnt", i), gnt, exp_gnt);
      tick(); tick();
      checkOutput($sformatf("tie%0d_acks", i), {ld_ack, cpu_ack}, exp_gnt);
      tick();
      checkOutput($sformatf("tie%0d_idle", i), busy, 0);
    end
    applyStimulus(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    checkOutput("tie_cpu_rdata", cpu_rdata, 32'h85);
    checkOutput("tie_ld_rdata", ld_rdata, 32'hCAFE_0123);

    $display("[TB] reset during CAPTURE of CPU read");
    applyStimulus(1, 0, 9'h055, 32'h0, 0, 0, 9'h0, 32'h0);
    tick();
    checkOutput("ab_mem_read", mem_read, 1);
    applyStimulus(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("ab_busy", busy, 0);
    checkOutput("ab_mem_read_low", mem_read, 0);
    checkOutput("ab_cpu_ack", cpu_ack, 0);
    checkOutput("ab_cpu_rdata", cpu_rdata, 0);
    checkOutput("ab_ld_rdata", ld_rdata, 0);
    checkOutput("ab_gnt", gnt, 0);
    reset = 1'b1;
    tick();
    checkOutput("ab_no_late_ack", cpu_ack, 0);

    $display("[TB] first tie after reset");
    applyStimulus(1, 1, 9'h030, 32'h3, 1, 1, 9'h031, 32'h4);
    tick();
    checkOutput("rt_gnt", gnt, 2'b01);
    applyStimulus(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    tick(); tick(); tick();

    $display("[TB] CPU request held through DONE");
    applyStimulus(1, 0, 9'h055, 32'h0, 0, 0, 9'h0, 32'h0);
    tick();
    checkOutput("hd_gnt1", gnt, 2'b01);
    tick(); tick();
    checkOutput("hd_ack1", cpu_ack, 1);
    tick();
    checkOutput("hd_gap_ack", cpu_ack, 0);
    checkOutput("hd_gap_busy", busy, 0);
    tick();
    checkOutput("hd_gnt2", gnt, 2'b01);
    checkOutput("hd_read2", mem_read, 1);
    applyStimulus(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    tick(); tick();
    checkOutput("hd_ack2", cpu_ack, 1);
    checkOutput("hd_rdata2", cpu_rdata, 32'h85);
    tick();
    checkOutput("hd_end_ack", cpu_ack, 0);
    tick();
    checkOutput("hd_no_third", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
